// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath widths and the 4-bit operation select codes.
// Consumers of the ALU (arbiter, execute units) import this package.
package alu_pkg;

    localparam int ALU_DW   = 32;
    localparam int ALU_SELW = 4;

    typedef logic [ALU_DW-1:0]   alu_word_t;
    typedef logic [ALU_SELW-1:0] alu_sel_t;

    localparam alu_sel_t ALU_GEZ  = 4'd0;
    localparam alu_sel_t ALU_LTZ  = 4'd1;
    localparam alu_sel_t ALU_ADD  = 4'd2;
    localparam alu_sel_t ALU_SUB  = 4'd3;
    localparam alu_sel_t ALU_AND  = 4'd4;
    localparam alu_sel_t ALU_OR   = 4'd5;
    localparam alu_sel_t ALU_XOR  = 4'd6;
    localparam alu_sel_t ALU_NOR  = 4'd7;
    localparam alu_sel_t ALU_SRL  = 4'd8;
    localparam alu_sel_t ALU_SRA  = 4'd9;
    localparam alu_sel_t ALU_SLL  = 4'd10;
    localparam alu_sel_t ALU_EQ   = 4'd11;
    localparam alu_sel_t ALU_SLT  = 4'd12;
    localparam alu_sel_t ALU_SLTU = 4'd13;
    localparam alu_sel_t ALU_GTZ  = 4'd14;
    localparam alu_sel_t ALU_LEZ  = 4'd15;

endpackage

// File: rtl/rr_arbiter.sv
// NREQ-way arbiter producing a one-hot grant plus its encoded index.
// Round-robin by default; defining ALU_ARB_FIXED_PRIO_EN gives fixed priority (lowest index wins).
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IDW  = 3
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [NREQ-1:0] req_valid,
    input  logic            advance,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_idx,
    output logic            grant_any
);

`ifdef ALU_ARB_FIXED_PRIO_EN
    // No pointer state in this mode; the clock, reset and advance strobe are intentionally unused.
    logic unused_ok;
    assign unused_ok = ^{clk, reset_n, advance};

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!grant_any && req_valid[i]) begin
                grant[i]  = 1'b1;
                grant_idx = IDW'(i);
                grant_any = 1'b1;
            end
        end
    end
`else
    logic [IDW-1:0] ptr_q, ptr_d;

    // NOTE: every output gets a default before the search loop, so no path leaves a latch behind.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        for (int off = 0; off < NREQ; off++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!grant_any && req_valid[i] && (i == (int'(ptr_q) + off) % NREQ)) begin
                    grant[i]  = 1'b1;
                    grant_idx = IDW'(i);
                    grant_any = 1'b1;
                end
            end
        end
    end

    // The pointer moves past the winner only when a transfer actually happens.
    always_comb begin
        ptr_d = ptr_q;
        if (advance) begin
            ptr_d = (int'(grant_idx) == NREQ - 1) ? '0 : grant_idx + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU among NREQ requesters and registers a single tagged response.
// Optional build macro: ALU_ARB_FIXED_PRIO_EN (fixed priority instead of round-robin).
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IDW  = 3
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [ALU_DW*NREQ-1:0] req_op1,
    input  logic [ALU_DW*NREQ-1:0] req_op2,
    input  logic [4*NREQ-1:0]      req_sel,
    output logic [ALU_DW-1:0]      alu_op1,
    output logic [ALU_DW-1:0]      alu_op2,
    output logic [ALU_SELW-1:0]    alu_sel,
    input  logic [ALU_DW-1:0]      alu_result,
    input  logic                   alu_zero,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [IDW-1:0]         rsp_id,
    output logic [ALU_DW-1:0]      rsp_result,
    output logic                   rsp_zero
);

    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  grant_idx;
    logic            grant_any;
    logic            can_accept;
    logic            xfer;

    logic            rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]  rsp_id_q, rsp_id_d;
    alu_word_t       rsp_result_q, rsp_result_d;
    logic            rsp_zero_q, rsp_zero_d;

    // The slot can take a new result when empty or when it is being drained this cycle.
    assign can_accept = !rsp_valid_q || rsp_ready;
    assign xfer       = grant_any && can_accept;
    assign req_ready  = grant & {NREQ{can_accept}};

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .advance   (xfer),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    always_comb begin
        alu_op1 = '0;
        alu_op2 = '0;
        alu_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                alu_op1 = req_op1[i*ALU_DW +: ALU_DW];
                alu_op2 = req_op2[i*ALU_DW +: ALU_DW];
                alu_sel = req_sel[i*ALU_SELW +: ALU_SELW];
            end
        end
    end

    // A new transfer wins over a drain, so back-to-back ops keep rsp_valid high.
    always_comb begin
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_zero_d   = rsp_zero_q;
        if (xfer) begin
            rsp_valid_d  = 1'b1;
            rsp_id_d     = grant_idx;
            rsp_result_d = alu_result;
            rsp_zero_d   = alu_zero;
        end else if (rsp_valid_q && rsp_ready) begin
            rsp_valid_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
        end else begin
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_zero_q   <= rsp_zero_d;
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_zero   = rsp_zero_q;

endmodule
